pmem_arbiter: RTL and testbench

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/rv32i_types.sv | 16 +
 rtl/rr_priority_select.sv | 34 +++
 rtl/pmem_arbiter.sv | 137 +++++++++++++
 tb/tb_pmem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the physical-memory arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / BUSY / RESP)
//   line_t      : a cache line at the default 256-bit line width
package rv32i_types;

   localparam int LINE_BITS = 256;

   typedef logic [LINE_BITS-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority selector (purely combinational).
// Scans the request vector starting at last_grant+1 (mod N) and returns the
// first requesting index.
//   request    : per-port request vector
//   last_grant : index of the most recently serviced port
//   grant      : selected port index (0 when valid is low)
//   valid      : at least one port is requesting
module rr_priority_select #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     request,
   input  logic [IDX_W-1:0] last_grant,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      // Offsets 1..N so the last granted port is considered last.
      for (int i = 1; i <= N; i++) begin
         idx = IDX_W'((int'(last_grant) + i) % N);
         if (!valid && request[idx]) begin
            valid = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates several cache ports onto one physical-memory port, one line
// transaction at a time, with round-robin fairness and per-port completion
// counters.
//   clk, rst                       : clock, synchronous active-high reset
//   req_read/req_write             : per-port line requests (write wins if both)
//   req_address/req_wdata          : per-port address and write line
//   req_resp/req_error/req_rdata   : one-cycle completion to the granted port
//   pmem_read/pmem_write           : memory command, asserted only in BUSY
//   pmem_address/pmem_wdata        : latched address / write line
//   pmem_resp/pmem_error/pmem_rdata: memory completion
//   stat_count/stat_reset          : per-port completed-transaction counters
//   dbg_state                      : current FSM state
//
// Handshake: a port raises req_read or req_write and holds it, with address
// and data, until the cycle in which its req_resp bit pulses. Memory holds
// off with pmem_resp low; pmem_resp high for one cycle completes the command.
module pmem_arbiter
   import rv32i_types::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_PORTS-1:0]                  req_read,
   input  logic [NUM_PORTS-1:0]                  req_write,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]                  req_resp,
   output logic [NUM_PORTS-1:0]                  req_error,
   output logic [LINE_WIDTH-1:0]                 req_rdata,
   output logic                                  pmem_read,
   output logic                                  pmem_write,
   output logic [ADDR_WIDTH-1:0]                 pmem_address,
   output logic [LINE_WIDTH-1:0]                 pmem_wdata,
   input  logic                                  pmem_resp,
   input  logic                                  pmem_error,
   input  logic [LINE_WIDTH-1:0]                 pmem_rdata,
   output logic [NUM_PORTS-1:0][31:0]            stat_count,
   input  logic                                  stat_reset,
   output arb_state_t                            dbg_state
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   arb_state_t             state, state_next;
   logic [IDX_W-1:0]       grant_q, last_grant_q, sel_grant;
   logic                   sel_valid;
   logic                   grant_load;
   logic                   op_write_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [LINE_WIDTH-1:0]  wdata_q;
   logic [LINE_WIDTH-1:0]  rdata_q;
   logic                   error_q;

   rr_priority_select #(
      .N     (NUM_PORTS),
      .IDX_W (IDX_W)
   ) u_select (
      .request    (req_read | req_write),
      .last_grant (last_grant_q),
      .grant      (sel_grant),
      .valid      (sel_valid)
   );

   // Next state and outputs
   always_comb begin
      state_next = state;
      grant_load = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      req_resp   = '0;
      req_error  = '0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               grant_load = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            pmem_read  = !op_write_q;
            pmem_write = op_write_q;
            if (pmem_resp) state_next = RESP;
         end
         RESP: begin
            req_resp[grant_q]  = 1'b1;
            req_error[grant_q] = error_q;
            state_next         = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign req_rdata    = rdata_q;
   assign dbg_state    = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_PORTS - 1);
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         error_q      <= 1'b0;
      end else begin
         state <= state_next;
         if (grant_load) begin
            grant_q    <= sel_grant;
            // A port raising both read and write is treated as a write.
            op_write_q <= req_write[sel_grant];
            addr_q     <= req_address[sel_grant];
            wdata_q    <= req_wdata[sel_grant];
         end
         if (state == BUSY && pmem_resp) begin
            rdata_q <= pmem_rdata;
            error_q <= pmem_error;
         end
         if (state == RESP) last_grant_q <= grant_q;
      end
   end

   // Completion counters; a clear request overrides a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stat_reset) begin
         stat_count <= '0;
      end else if (state == RESP) begin
         stat_count[grant_q] <= stat_count[grant_q] + 32'd1;
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
   import rv32i_types::*;

   localparam int NP = 2;
   localparam int LW = 256;
   localparam int AW = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]          req_read, req_write, req_resp, req_error;
   logic [NP-1:0][AW-1:0]  req_address;
   logic [NP-1:0][LW-1:0]  req_wdata;
   logic [LW-1:0]          req_rdata, pmem_wdata, pmem_rdata;
   logic                   pmem_read, pmem_write, pmem_resp, pmem_error, stat_reset;
   logic [AW-1:0]          pmem_address;
   logic [NP-1:0][31:0]    stat_count;
   arb_state_t             dbg_state;

   pmem_arbiter #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata),
      .req_resp(req_resp), .req_error(req_error), .req_rdata(req_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata),
      .stat_count(stat_count), .stat_reset(stat_reset),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   // entry = {port, error, rdata}
   logic [LW+1:0] exp_q[$];
   int unsigned   exp_cnt[NP];

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   logic [LW+1:0] mon_e;
   logic [NP-1:0] mon_oh;
   always @(negedge clk) begin
      if (req_resp !== '0) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got req_resp=%b, want none", req_resp);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_oh = '0;
            mon_oh[mon_e[LW+1]] = 1'b1;
            check("resp_port", LW'(req_resp), LW'(mon_oh));
            check("resp_error", LW'(req_error), mon_e[LW] ? LW'(mon_oh) : '0);
            check("resp_rdata", req_rdata, mon_e[LW-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
   endtask

   task automatic check_counts();
      for (int p = 0; p < NP; p++)
         check($sformatf("stat_count%0d", p), LW'(stat_count[p]), LW'(exp_cnt[p]));
   endtask

   // Called at posedge+1 of an IDLE cycle with the requests already driven.
   task automatic serve(input int port, input logic wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wd, input int delay, input logic [LW-1:0] rd,
                        input logic err, input logic scramble, input logic sreset);
      int waits = 0;
      exp_q.push_back({port[0], err, rd});
      @(negedge clk);
      while (!(pmem_read || pmem_write) && waits < 10) begin
         waits++;
         @(negedge clk);
      end
      check("cmd_latency", LW'(waits), LW'(1));
      if (waits >= 10) begin
         exp_q.delete();
         return;
      end
      for (int c = 1; c <= delay; c++) begin
         check("pmem_read", LW'(pmem_read), LW'(!wr));
         check("pmem_write", LW'(pmem_write), LW'(wr));
         check("pmem_address", LW'(pmem_address), LW'(addr));
         check("pmem_wdata", pmem_wdata, wd);
         if (scramble && c == 1) begin
            req_address = {NP{32'hdead_beef}};
            req_wdata   = '1;
         end
         if (c == delay) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
            pmem_error = err;
         end
         @(posedge clk); #1;
         if (c == delay) begin
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
            pmem_error = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      // Now inside the RESP cycle.
      stat_reset = sreset;
      @(posedge clk); #1;
      stat_reset = 1'b0;
      check("resp_seen", LW'(exp_q.size()), '0);
      if (sreset) for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
      else exp_cnt[port] = exp_cnt[port] + 1;
   endtask

   // ---------------- directed tests ----------------
   logic [LW-1:0] pat_a, pat_b, pat_c, pat_d;

   initial begin
      pat_a = {8{32'ha5a5_5a5a}};
      pat_b = {8{32'h1234_5678}};
      pat_c = {8{32'hc0de_0c0c}};
      pat_d = {8{32'hdada_0d0d}};
      req_read = '0; req_write = '0; req_address = '0; req_wdata = '0;
      pmem_resp = 1'b0; pmem_error = 1'b0; pmem_rdata = '0; stat_reset = 1'b0;

      // Reset values
      do_reset();
      @(negedge clk);
      check("rst_pmem_read", LW'(pmem_read), '0);
      check("rst_pmem_write", LW'(pmem_write), '0);
      check("rst_pmem_address", LW'(pmem_address), '0);
      check("rst_pmem_wdata", pmem_wdata, '0);
      check("rst_req_resp", LW'(req_resp), '0);
      check("rst_req_error", LW'(req_error), '0);
      check("rst_req_rdata", req_rdata, '0);
      check("rst_state", LW'(dbg_state), LW'(IDLE));
      check_counts();
      @(posedge clk); #1;

      // Single read, response after 3 BUSY cycles
      req_read[0] = 1'b1; req_address[0] = 32'h0000_1000;
      serve(0, 1'b0, 32'h0000_1000, '0, 3, pat_a, 1'b0, 1'b0, 1'b0);
      req_read = '0;
      check_counts();

      // Contention from reset: strict alternation 0,1,0,1
      do_reset();
      req_read = 2'b11; req_address[0] = 32'h0000_0100; req_address[1] = 32'h0000_0200;
      serve(0, 1'b0, 32'h0000_0100, '0, 1, pat_a, 1'b0, 1'b0, 1'b0);
      serve(1, 1'b0, 32'h0000_0200, '0, 2, pat_b, 1'b0, 1'b0, 1'b0);
      serve(0, 1'b0, 32'h0000_0100, '0, 1, pat_c, 1'b0, 1'b0, 1'b0);
      serve(1, 1'b0, 32'h0000_0200, '0, 2, pat_d, 1'b0, 1'b0, 1'b0);
      req_read = '0;
      check_counts();

      // Write from port 1; inputs scrambled during BUSY must not matter
      req_write[1] = 1'b1; req_address[1] = 32'h0000_2040; req_wdata[1] = pat_b;
      serve(1, 1'b1, 32'h0000_2040, pat_b, 3, '0, 1'b0, 1'b1, 1'b0);
      req_write = '0; req_address = '0; req_wdata = '0;
      check_counts();

      // Read and write together is a write
      req_read[0] = 1'b1; req_write[0] = 1'b1;
      req_address[0] = 32'h0000_3000; req_wdata[0] = pat_c;
      serve(0, 1'b1, 32'h0000_3000, pat_c, 2, '0, 1'b0, 1'b0, 1'b0);
      req_read = '0; req_write = '0; req_wdata = '0;

      // Memory error forwarded, counter still increments
      req_read[1] = 1'b1; req_address[1] = 32'h0000_4000;
      serve(1, 1'b0, 32'h0000_4000, '0, 2, pat_d, 1'b1, 1'b0, 1'b0);
      req_read = '0;
      check_counts();

      // Reset during BUSY cycle 2, then a stray pmem_resp in IDLE
      req_read[0] = 1'b1; req_address[0] = 32'h0000_5000;
      @(negedge clk);
      @(negedge clk);
      check("busy_pmem_read", LW'(pmem_read), LW'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_read = '0;
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
      @(negedge clk);
      check("abort_pmem_read", LW'(pmem_read), '0);
      check("abort_state", LW'(dbg_state), LW'(IDLE));
      pmem_resp = 1'b1; pmem_error = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b0; pmem_error = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("stray_req_resp", LW'(req_resp), '0);
      check("stray_pmem_read", LW'(pmem_read), '0);
      check_counts();
      @(posedge clk); #1;

      // stat_reset coincides with the RESP that would make port 0 count 6
      req_read[0] = 1'b1; req_address[0] = 32'h0000_6000;
      for (int n = 0; n < 5; n++)
         serve(0, 1'b0, 32'h0000_6000, '0, 1, pat_a, 1'b0, 1'b0, 1'b0);
      check_counts();
      serve(0, 1'b0, 32'h0000_6000, '0, 1, pat_b, 1'b0, 1'b0, 1'b1);
      req_read = '0;
      check_counts();

      repeat (3) @(posedge clk);
      check("queue_drained", LW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, want finish before 100000");
      $fatal(1, "watchdog");
   end

endmodule
